demux_scheduler: RTL and testbench
==================================

# demux_scheduler

Sequencing controller for the 1-to-8 demultiplexer datapath. Accepts items from a single upstream source via valid/ready and steers each one to one of eight downstream consumers by driving the demux select and a one-hot valid. Destinations are picked either round-robin among ready consumers or from an explicit per-item destination. Sits between the upstream producer and the 8-way demux fan-out.

## Interface
- DW, 1: data width of one item (1 matches the single-bit demux input).
- TIMEOUT, 15: round-robin HOLD wait limit in cycles before re-arbitration; range 1..255.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream item present.
- in_data  in  DW  upstream item.
- in_mode  in  1  0 = round-robin destination, 1 = fixed destination from in_dest.
- in_dest  in  3  destination index, used only when in_mode=1.
- in_ready  out  1  scheduler can accept an item this cycle.
- out_ready  in  8  per-destination ready.
- out_valid  out  8  one-hot valid; bit sel set only in HOLD, otherwise 0.
- out_data  out  DW  item being delivered (demux data input).
- sel  out  3  demux select / current destination.
- retry  out  1  one-cycle pulse when a round-robin HOLD times out.
- count  out  8  total items delivered, wraps 255 -> 0.

## Operation
- States: IDLE, ARB, HOLD.
- Accept: handshake when in_valid && in_ready. On accept, register in_data, in_mode and in_dest; next state ARB.
- in_ready = !rst && (state==IDLE || (state==HOLD && out_ready[sel])). Combinational from out_ready in HOLD; allows back-to-back items.
- IDLE: no accept -> stay IDLE.
- ARB (one cycle), mode 0: scan out_ready starting at ptr, ascending, wrapping 7 -> 0; first set bit becomes sel, next state HOLD. No bit set -> stay ARB, sel unchanged.
- ARB, mode 1: sel = latched dest; next HOLD unconditionally.
- HOLD: out_valid[sel]=1, out_data = latched item. Delivery when out_ready[sel]=1: count+1, ptr = sel+1 mod 8, next state ARB if a new item is accepted the same cycle, else IDLE.
- HOLD timeout (mode 0 only): wait counter cleared on HOLD entry, increments each HOLD cycle without delivery. When it reaches TIMEOUT: retry pulses for one cycle, ptr = sel+1 mod 8, next state ARB with the item kept. Mode 1 waits indefinitely.
- ptr changes only on delivery or timeout.
- Mode-1 deliveries also advance ptr.

## Timing
- Reset (rst high at an edge): state IDLE, ptr 0, sel 0, out_data 0, count 0, retry 0, wait counter 0. out_valid = 0 and in_ready = 0 while rst is high. in_ready = 1 the first cycle after release.
- Reset mid-operation: any held item is discarded and no out_valid follows. The reset cycle itself is not a delivery.
- Latency: accept at edge t -> ARB during t+1 -> out_valid during t+2 at the earliest.
- Sustained throughput is one item per 2 cycles (HOLD/ARB alternating) with always-ready consumers and continuous input.
- retry is high only in the cycle after the timeout edge (registered).
- count wraps 255 -> 0 with no flag.

## Test plan
- Reset then round-robin, out_ready=8'hFF, four items (data 1,0,1,1, mode 0) -> delivered with sel 0,1,2,3, out_valid 01,02,04,08, first out_valid 2 cycles after accept, count=4.
- Skip and wrap: ptr=6, out_ready=8'b0000_0101 -> sel=0. Next item -> sel=2. With out_ready=0 in ARB, the scheduler stays in ARB and out_valid=0 until a bit rises.
- Fixed mode: in_mode=1, in_dest=5, out_ready[5]=0 for 40 cycles -> out_valid=8'h20 held 40 cycles, retry never asserted. out_ready[5]=1 -> delivered, ptr=6.
- Timeout: TIMEOUT=15, mode 0, ptr 3; out_ready[3]=1 only in ARB, then dropped -> retry pulses after 15 HOLD cycles. Re-ARB picks the next ready index from 4.
- Back-to-back: in_valid held with out_ready=FF -> in_ready high on each HOLD delivery cycle; 10 items delivered in 20 cycles; count=10.
- Reset during HOLD (out_valid=8'h04) -> next cycle out_valid=0, in_ready=0 while rst is high; after release IDLE, count=0, sel=0, the held item is never delivered.

Source files
------------

// File: rtl/demux_scheduler.sv
// demux_scheduler: steers single-source items to one of eight consumers,
// round-robin among ready consumers or to an explicit per-item destination.
module demux_scheduler #(
   parameter int DW      = 1,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_mode,
   input  logic [2:0]    in_dest,
   output logic          in_ready,
   input  logic [7:0]    out_ready,
   output logic [7:0]    out_valid,
   output logic [DW-1:0] out_data,
   output logic [2:0]    sel,
   output logic          retry,
   output logic [7:0]    count
);

   typedef enum logic [1:0] {IDLE, ARB, HOLD} state_t;

   state_t          state;
   logic [2:0]      ptr;
   logic [2:0]      dest_q;
   logic            mode_q;
   logic [DW-1:0]   data_q;
   logic [7:0]      wcnt;
   logic [2:0]      pick;
   logic            found;
   logic            deliver;
   logic            accept;
   logic            timeout;

   // Scan downward so the last hit written is the lowest offset from ptr.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      for (int unsigned i = 8; i > 0; i--) begin
         if (out_ready[ptr + 3'(i - 1)]) begin
            found = 1'b1;
            pick  = ptr + 3'(i - 1);
         end
      end
   end

   assign deliver   = (state == HOLD) && out_ready[sel];
   assign in_ready  = !rst && ((state == IDLE) || deliver);
   assign accept    = in_valid && in_ready;
   assign timeout   = (state == HOLD) && !out_ready[sel] && !mode_q &&
                      (wcnt == 8'(TIMEOUT - 1));
   assign out_valid = (!rst && state == HOLD) ? (8'b1 << sel) : '0;
   assign out_data  = data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= '0;
         sel    <= '0;
         data_q <= '0;
         mode_q <= 1'b0;
         dest_q <= '0;
         wcnt   <= '0;
         count  <= '0;
         retry  <= 1'b0;
      end else begin
         retry <= 1'b0;
         if (accept) begin
            data_q <= in_data;
            mode_q <= in_mode;
            dest_q <= in_dest;
         end
         case (state)
            IDLE: if (accept) state <= ARB;
            ARB: begin
               if (mode_q) begin
                  sel   <= dest_q;
                  wcnt  <= '0;
                  state <= HOLD;
               end else if (found) begin
                  sel   <= pick;
                  wcnt  <= '0;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (deliver) begin
                  count <= count + 8'd1;
                  ptr   <= sel + 3'd1;
                  state <= accept ? ARB : IDLE;
               end else if (timeout) begin
                  retry <= 1'b1;
                  ptr   <= sel + 3'd1;
                  wcnt  <= '0;
                  state <= ARB;
               end else if (!mode_q) begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler: inputs change 1 ns after the rising
// edge, outputs are checked 2 ns after it.
module tb_demux_scheduler;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [0:0] in_data;
   logic       in_mode;
   logic [2:0] in_dest;
   logic       in_ready;
   logic [7:0] out_ready;
   logic [7:0] out_valid;
   logic [0:0] out_data;
   logic [2:0] sel;
   logic       retry;
   logic [7:0] count;

   int n_assert = 0;
   int n_fail   = 0;

   demux_scheduler #(.DW(1), .TIMEOUT(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .in_dest   (in_dest),
      .in_ready  (in_ready),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sel       (sel),
      .retry     (retry),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One item from IDLE to a ready destination and back to IDLE.
   task automatic item(input logic d, input logic m, input logic [2:0] dst,
                       input logic [2:0] esel, input logic [7:0] ecnt);
      in_valid = 1'b1; in_data = d; in_mode = m; in_dest = dst;
      settle();
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      settle();
      chk("arb_out_valid", 32'(out_valid), 32'd0);
      chk("arb_in_ready", 32'(in_ready), 32'd0);
      tick();
      settle();
      chk("hold_out_valid", 32'(out_valid), 32'(8'b1 << esel));
      chk("hold_sel", 32'(sel), 32'(esel));
      chk("hold_out_data", 32'(out_data), 32'(d));
      chk("hold_in_ready", 32'(in_ready), 32'd1);
      tick();
      settle();
      chk("count", 32'(count), 32'(ecnt));
      chk("back_idle_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
      in_dest = '0; out_ready = '0;
      tick(); tick();
      settle();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_retry", 32'(retry), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      settle();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Round robin with all consumers ready
      out_ready = 8'hFF;
      item(1'b1, 1'b0, 3'd0, 3'd0, 8'd1);
      item(1'b0, 1'b0, 3'd0, 3'd1, 8'd2);
      item(1'b1, 1'b0, 3'd0, 3'd2, 8'd3);
      item(1'b1, 1'b0, 3'd0, 3'd3, 8'd4);

      // Bring ptr to 6, then skip and wrap
      item(1'b0, 1'b0, 3'd0, 3'd4, 8'd5);
      item(1'b1, 1'b0, 3'd0, 3'd5, 8'd6);
      out_ready = 8'b0000_0101;
      item(1'b1, 1'b0, 3'd0, 3'd0, 8'd7);
      item(1'b0, 1'b0, 3'd0, 3'd2, 8'd8);

      // Nothing ready in ARB: stays in ARB until bit 7 rises (ptr 3)
      out_ready = 8'h00;
      in_valid = 1'b1; in_data = 1'b1; in_mode = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("arb_wait_out_valid", 32'(out_valid), 32'd0);
         chk("arb_wait_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 8'h80;
      tick();
      settle();
      chk("arb_late_out_valid", 32'(out_valid), 32'h80);
      chk("arb_late_sel", 32'(sel), 32'd7);
      tick();
      settle();
      chk("arb_late_count", 32'(count), 32'd9);

      // Fixed destination 5 held off for 40 cycles, no retry
      out_ready = 8'hDF;
      in_valid = 1'b1; in_data = 1'b0; in_mode = 1'b1; in_dest = 3'd5;
      tick();
      in_valid = 1'b0;
      tick();
      for (int i = 0; i < 40; i++) begin
         settle();
         chk("fixed_out_valid", 32'(out_valid), 32'h20);
         chk("fixed_retry", 32'(retry), 32'd0);
         tick();
      end
      out_ready = 8'hFF;
      settle();
      chk("fixed_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      settle();
      chk("fixed_count", 32'(count), 32'd10);
      item(1'b1, 1'b0, 3'd0, 3'd6, 8'd11);

      // Walk ptr to 3
      item(1'b0, 1'b0, 3'd0, 3'd7, 8'd12);
      item(1'b1, 1'b0, 3'd0, 3'd0, 8'd13);
      item(1'b0, 1'b0, 3'd0, 3'd1, 8'd14);
      item(1'b1, 1'b0, 3'd0, 3'd2, 8'd15);

      // Timeout: consumer 3 ready only in ARB
      out_ready = 8'h08;
      in_valid = 1'b1; in_data = 1'b1; in_mode = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      out_ready = 8'h00;
      for (int i = 0; i < 15; i++) begin
         settle();
         chk("to_hold_out_valid", 32'(out_valid), 32'h08);
         chk("to_hold_retry", 32'(retry), 32'd0);
         tick();
      end
      out_ready = 8'h18;
      settle();
      chk("to_retry", 32'(retry), 32'd1);
      chk("to_arb_out_valid", 32'(out_valid), 32'd0);
      tick();
      settle();
      chk("to_retry_clear", 32'(retry), 32'd0);
      chk("to_rearb_sel", 32'(sel), 32'd4);
      chk("to_rearb_out_valid", 32'(out_valid), 32'h10);
      chk("to_rearb_out_data", 32'(out_data), 32'd1);
      tick();
      settle();
      chk("to_count", 32'(count), 32'd16);

      // Back-to-back, ptr starts at 5
      out_ready = 8'hFF;
      in_valid = 1'b1; in_data = 1'b0; in_mode = 1'b0;
      tick();
      for (int k = 0; k < 10; k++) begin
         settle();
         chk("b2b_arb_in_ready", 32'(in_ready), 32'd0);
         tick();
         settle();
         chk("b2b_out_valid", 32'(out_valid), 32'(8'b1 << 3'((5 + k) % 8)));
         chk("b2b_out_data", 32'(out_data), 32'(k % 2));
         chk("b2b_hold_in_ready", 32'(in_ready), 32'd1);
         in_data = 1'((k + 1) % 2);
         if (k == 9) in_valid = 1'b0;
         tick();
      end
      settle();
      chk("b2b_count", 32'(count), 32'd26);
      chk("b2b_idle_in_ready", 32'(in_ready), 32'd1);

      // Reset while holding for destination 2
      out_ready = 8'h00;
      in_valid = 1'b1; in_data = 1'b1; in_mode = 1'b1; in_dest = 3'd2;
      tick();
      in_valid = 1'b0;
      tick();
      settle();
      chk("rh_out_valid", 32'(out_valid), 32'h04);
      rst = 1'b1;
      settle();
      chk("rh_rst_out_valid", 32'(out_valid), 32'd0);
      chk("rh_rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      settle();
      chk("rh_after_edge_in_ready", 32'(in_ready), 32'd0);
      chk("rh_count", 32'(count), 32'd0);
      chk("rh_sel", 32'(sel), 32'd0);
      rst = 1'b0;
      out_ready = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("rh_no_delivery", 32'(out_valid), 32'd0);
         chk("rh_idle_in_ready", 32'(in_ready), 32'd1);
         tick();
      end
      settle();
      chk("rh_final_count", 32'(count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
